mem_port_arbiter: RTL
=====================

Name: mem_port_arbiter

Overview:
- Shares the single-ported, word-addressed CPU memory between two requesters: the instruction-fetch port (I, read-only) and the load/store port (D, read/write).
- Arbitration is data-priority with an anti-starvation counter for fetch.
- Read data returns one cycle after grant, matching the synchronous memory.
- Write-protects the .text segment (word addresses below DATA_BASE). It sits between the fetch/LSU stages and the memory instance inside fake_cpu.

Parameters:
- ADDR_WIDTH, 12, word-address width (4096 words).
- DATA_WIDTH, 32, word width.
- DATA_BASE, 2048, first word address of .data; addresses below it are .text.
- TEXT_WP, 1, when 1, D writes to addresses below DATA_BASE are suppressed and flagged.
- STARVE_LIMIT, 4, consecutive denied I cycles before I is force-granted (range 1..15).

Ports:
- clk  in  1  clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high reset.
- i_req  in  1  fetch request; addr held stable until granted.
- i_addr  in  ADDR_WIDTH  fetch word address.
- i_gnt  out  1  fetch accepted this cycle (combinational).
- i_rvalid  out  1  fetch data valid (registered, 1 cycle after i_gnt).
- i_rdata  out  DATA_WIDTH  fetch data; 0 when i_rvalid=0.
- d_req  in  1  load/store request; inputs held stable until granted.
- d_we  in  1  1=store, 0=load.
- d_addr  in  ADDR_WIDTH  data word address.
- d_wdata  in  DATA_WIDTH  store data.
- d_gnt  out  1  data access accepted this cycle (combinational).
- d_rvalid  out  1  load data valid (1 cycle after load grant).
- d_rdata  out  DATA_WIDTH  load data; 0 when d_rvalid=0.
- d_err  out  1  one-cycle pulse, 1 cycle after a blocked .text store.
- mem_en  out  1  memory access strobe.
- mem_we  out  1  memory write enable.
- mem_addr  out  ADDR_WIDTH  memory word address.
- mem_wdata  out  DATA_WIDTH  memory write data.
- mem_rdata  in  DATA_WIDTH  read data, valid the cycle after mem_en & !mem_we.

Behaviour:
- Reset (synchronous, active-high):
  - Clears wait_cnt, the response-select register and the d_err flop.
  - While reset=1: i_gnt=d_gnt=0, mem_en=mem_we=0, i_rvalid=d_rvalid=d_err=0, rdata outputs 0.
  - A read granted in the cycle before reset asserts yields no rvalid.
- Grant (combinational, at most one per cycle):
  - force_i = i_req & (wait_cnt == STARVE_LIMIT).
  - i_gnt = i_req & (force_i | !d_req).
  - d_gnt = d_req & !i_gnt.
  - A handshake completes at the clock edge where req & gnt.
- Memory drive:
  - mem_en = i_gnt | d_gnt.
  - mem_addr comes from the granted port; mem_addr = 0 when idle.
  - mem_wdata = d_wdata.
  - mem_we = d_gnt & d_we & !(TEXT_WP & d_addr < DATA_BASE).
- Starvation counter wait_cnt (4 bits):
  - Next value = 0 if !i_req or i_gnt.
  - Otherwise min(wait_cnt+1, STARVE_LIMIT).
  - With continuous d_req and i_req, I is granted exactly once every STARVE_LIMIT+1 cycles.
- Response (registered resp_sel ∈ {NONE, I, D}):
  - Set to I on an I grant, to D on a D load grant, NONE otherwise.
  - i_rvalid = (resp_sel == I); d_rvalid = (resp_sel == D).
  - The rdata of the selected port = mem_rdata; the other port's rdata = 0.
  - Back-to-back grants give back-to-back rvalids; there is no pipeline bubble.
- Stores: complete at grant; they produce no rvalid.
- Blocked store (TEXT_WP=1, d_we=1, d_addr < DATA_BASE):
  - Granted (requester unblocked), mem_en=1, mem_we=0.
  - d_err=1 in the next cycle.
  - Memory contents unchanged.
- I requests to any address (including .data) are legal, with no checking.
- The requester must not drop req before gnt. Dropping it early is not an error: it clears wait_cnt.

Test Plan:
- Reset, then i_req with i_addr=0x000 and memory[0]=0x20080005: i_gnt same cycle; the next cycle i_rvalid=1, i_rdata=0x20080005; other outputs 0.
- Simultaneous i_req (addr 0x004) and d_req load (addr 0x800): d_gnt in cycle 0, i_gnt in cycle 1; d_rvalid in cycle 1, i_rvalid in cycle 2; no overlap of gnts.
- d_req held continuously with random addresses ≥0x800 while i_req held, STARVE_LIMIT=4: i_gnt in exactly cycles 4, 9, 14; wait_cnt never exceeds 4.
- Store d_addr=0x900, d_wdata=0xDEADBEEF, then load 0x900: mem_we=1 on the store; the load returns 0xDEADBEEF; d_err stays 0.
- Store d_addr=0x010 with TEXT_WP=1: d_gnt=1, mem_we=0, d_err pulse next cycle; a later fetch of 0x010 returns the original word.
- Reset asserted the cycle after a load grant: no d_rvalid; all outputs 0 during reset; normal grant the first cycle after reset deasserts.

Source files
------------

// File: rtl/mem_port_arbiter_if.sv
// Bundle of fetch, load/store and memory-side signals shared by the arbiter and its neighbours.
// The slave modport is the arbiter's view; the master modport is the requesters plus the memory.
interface mem_port_arbiter_if #(
  parameter int ADDR_WIDTH = 12,
  parameter int DATA_WIDTH = 32
);
  logic                  i_req;
  logic [ADDR_WIDTH-1:0] i_addr;
  logic                  i_gnt;
  logic                  i_rvalid;
  logic [DATA_WIDTH-1:0] i_rdata;

  logic                  d_req;
  logic                  d_we;
  logic [ADDR_WIDTH-1:0] d_addr;
  logic [DATA_WIDTH-1:0] d_wdata;
  logic                  d_gnt;
  logic                  d_rvalid;
  logic [DATA_WIDTH-1:0] d_rdata;
  logic                  d_err;

  logic                  mem_en;
  logic                  mem_we;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [DATA_WIDTH-1:0] mem_wdata;
  logic [DATA_WIDTH-1:0] mem_rdata;

  modport slave (
    input  i_req, i_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
    output i_gnt, i_rvalid, i_rdata, d_gnt, d_rvalid, d_rdata, d_err,
    output mem_en, mem_we, mem_addr, mem_wdata
  );

  modport master (
    output i_req, i_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
    input  i_gnt, i_rvalid, i_rdata, d_gnt, d_rvalid, d_rdata, d_err,
    input  mem_en, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Shares one synchronous single-port memory between fetch (I) and load/store (D).
// D has priority; a starved fetch is force-granted after STARVE_LIMIT denied cycles.
module mem_port_arbiter #(
  parameter int ADDR_WIDTH   = 12,
  parameter int DATA_WIDTH   = 32,
  parameter int DATA_BASE    = 2048,
  parameter int TEXT_WP      = 1,
  parameter int STARVE_LIMIT = 4
) (
  input logic             clk,
  input logic             reset,
  mem_port_arbiter_if.slave bus
);

  localparam logic [3:0]            LIMIT     = 4'(STARVE_LIMIT);
  localparam logic [ADDR_WIDTH-1:0] TEXT_END  = ADDR_WIDTH'(DATA_BASE);
  localparam logic                  WP_ENABLE = (TEXT_WP != 0);

  typedef enum logic [1:0] {
    RESP_NONE = 2'd0,
    RESP_I    = 2'd1,
    RESP_D    = 2'd2
  } resp_e;

  resp_e      resp_sel_q, resp_sel_d;
  logic [3:0] wait_cnt_q, wait_cnt_d;
  logic       d_err_q, d_err_d;

  logic force_i;
  logic i_gnt;
  logic d_gnt;
  logic text_store;

  always_comb begin
    force_i    = bus.i_req && (wait_cnt_q == LIMIT);
    i_gnt      = !reset && bus.i_req && (force_i || !bus.d_req);
    d_gnt      = !reset && bus.d_req && !i_gnt;
    text_store = WP_ENABLE && bus.d_we && (bus.d_addr < TEXT_END);

    // Counter saturates at the limit so a force grant stays armed until taken.
    wait_cnt_d = wait_cnt_q;
    if (!bus.i_req || i_gnt) begin
      wait_cnt_d = 4'd0;
    end else if (wait_cnt_q < LIMIT) begin
      wait_cnt_d = wait_cnt_q + 4'd1;
    end

    resp_sel_d = RESP_NONE;
    if (i_gnt) begin
      resp_sel_d = RESP_I;
    end else if (d_gnt && !bus.d_we) begin
      resp_sel_d = RESP_D;
    end

    d_err_d = d_gnt && text_store;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      resp_sel_q <= RESP_NONE;
      wait_cnt_q <= 4'd0;
      d_err_q    <= 1'b0;
    end else begin
      resp_sel_q <= resp_sel_d;
      wait_cnt_q <= wait_cnt_d;
      d_err_q    <= d_err_d;
    end
  end

  // Responses are masked during reset so a grant taken just before reset never surfaces.
  always_comb begin
    bus.i_gnt     = i_gnt;
    bus.d_gnt     = d_gnt;
    bus.i_rvalid  = !reset && (resp_sel_q == RESP_I);
    bus.d_rvalid  = !reset && (resp_sel_q == RESP_D);
    bus.i_rdata   = bus.i_rvalid ? bus.mem_rdata : '0;
    bus.d_rdata   = bus.d_rvalid ? bus.mem_rdata : '0;
    bus.d_err     = !reset && d_err_q;
    bus.mem_en    = i_gnt || d_gnt;
    bus.mem_we    = d_gnt && bus.d_we && !text_store;
    bus.mem_wdata = bus.d_wdata;
    bus.mem_addr  = '0;
    if (i_gnt) begin
      bus.mem_addr = bus.i_addr;
    end else if (d_gnt) begin
      bus.mem_addr = bus.d_addr;
    end
  end

endmodule
